// File: rtl/estimador_meas_seq.sv
// rtl/estimador_meas_seq.sv - frame sequencer feeding the estimator's 3:1 channel mux
//
// Purpose:
//   Accepts one frame of three signed samples through a valid/ready handshake.
//   The samples are held on the mux data inputs. The 2-bit select then steps
//   0 -> 1 -> 2, with one downstream handshake per channel. Select code 3 is
//   never driven.
//
// Optional feature macro: ESTW21_SAT_EN
//   When defined, each sample is clamped on capture to [-SAT_LIMIT, +SAT_LIMIT].
//   When undefined, samples are captured bit-exact.
//
// Ports:
//   ap_clk    in   1      clock, rising edge
//   ap_rst_n  in   1      asynchronous active-low reset
//   s_valid   in   1      input frame valid
//   s_ready   out  1      frame can be accepted (IDLE only)
//   s_ch0..2  in   W      channel samples
//   m_d0..2   out  W      captured samples, drive mux din0..din2
//   m_sel     out  2      mux select, 0..2
//   m_valid   out  1      selected channel valid downstream
//   m_ready   in   1      downstream consumed the selected channel
//   m_last    out  1      high with m_valid while m_sel == 2
//   ovr_cnt   out  OVR_W  saturating count of cycles a frame was offered while busy

module estimador_meas_seq #(
    parameter int           W         = 21,
    parameter logic [W-2:0] SAT_LIMIT = 20'hFFFFF,
    parameter int           OVR_W     = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_ch0,
    input  logic [W-1:0]     s_ch1,
    input  logic [W-1:0]     s_ch2,
    output logic [W-1:0]     m_d0,
    output logic [W-1:0]     m_d1,
    output logic [W-1:0]     m_d2,
    output logic [1:0]       m_sel,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [OVR_W-1:0] ovr_cnt
);

`ifdef ESTW21_SAT_EN
    localparam bit L_SAT_EN = 1'b1;
`else
    localparam bit L_SAT_EN = 1'b0;
`endif

    localparam logic signed [W-1:0] L_POS = $signed({1'b0, SAT_LIMIT});
    localparam logic signed [W-1:0] L_NEG = -L_POS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CH0  = 2'd1,
        ST_CH1  = 2'd2,
        ST_CH2  = 2'd3
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_d0, r_d1, r_d2;
    logic [1:0]       r_sel;
    logic             r_valid;
    logic             r_last;
    logic [OVR_W-1:0] r_ovr;

    logic [W-1:0]     w_cap0, w_cap1, w_cap2;
    logic             w_xfer;

    // Clamp is a pass-through unless the saturation build option is enabled.
    function automatic logic [W-1:0] f_clamp(input logic [W-1:0] x);
        logic signed [W-1:0] v;
        v = $signed(x);
        if (!L_SAT_EN) return x;
        if (v > L_POS) return L_POS;
        if (v < L_NEG) return L_NEG;
        return x;
    endfunction

    assign w_cap0 = f_clamp(s_ch0);
    assign w_cap1 = f_clamp(s_ch1);
    assign w_cap2 = f_clamp(s_ch2);

    // Ready depends on state only, so upstream never sees a path from m_ready.
    assign s_ready = (r_state == ST_IDLE);
    assign w_xfer  = r_valid & m_ready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
            r_d0    <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_sel   <= 2'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ovr   <= '0;
        end else begin
            // A frame offered while busy is refused and counted once per cycle.
            if (s_valid && (r_state != ST_IDLE) && (r_ovr != {OVR_W{1'b1}}))
                r_ovr <= r_ovr + {{(OVR_W-1){1'b0}}, 1'b1};

            case (r_state)
                ST_IDLE: begin
                    if (s_valid) begin
                        r_d0    <= w_cap0;
                        r_d1    <= w_cap1;
                        r_d2    <= w_cap2;
                        r_sel   <= 2'd0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_state <= ST_CH0;
                    end
                end
                ST_CH0: begin
                    if (w_xfer) begin
                        r_sel   <= 2'd1;
                        r_state <= ST_CH1;
                    end
                end
                ST_CH1: begin
                    if (w_xfer) begin
                        r_sel   <= 2'd2;
                        r_last  <= 1'b1;
                        r_state <= ST_CH2;
                    end
                end
                ST_CH2: begin
                    // Select keeps 2 in IDLE; data holds until the next capture.
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_d0    = r_d0;
    assign m_d1    = r_d1;
    assign m_d2    = r_d2;
    assign m_sel   = r_sel;
    assign m_valid = r_valid;
    assign m_last  = r_last;
    assign ovr_cnt = r_ovr;

endmodule

// File: tb/tb_estimador_meas_seq.sv
// tb/tb_estimador_meas_seq.sv - scoreboard bench for estimador_meas_seq
module tb_estimador_meas_seq;

    localparam int W     = 21;
    localparam int OVR_W = 8;

    logic             ap_clk;
    logic             ap_rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_ch0, s_ch1, s_ch2;
    logic [W-1:0]     m_d0, m_d1, m_d2;
    logic [1:0]       m_sel;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [OVR_W-1:0] ovr_cnt;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t sb[$];

    estimador_meas_seq #(
        .W         (W),
        .SAT_LIMIT (20'd1000),
        .OVR_W     (OVR_W)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_ch0    (s_ch0),
        .s_ch1    (s_ch1),
        .s_ch2    (s_ch2),
        .m_d0     (m_d0),
        .m_d1     (m_d1),
        .m_d2     (m_d2),
        .m_sel    (m_sel),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .ovr_cnt  (ovr_cnt)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic logic [W-1:0] s21(input int v);
        return v[W-1:0];
    endfunction

    // Reference clamp used only for the saturation build.
    function automatic int ref_cap(input int v);
`ifdef ESTW21_SAT_EN
        if (v > 1000)  return 1000;
        if (v < -1000) return -1000;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive_frame(input int a, input int b, input int c);
        exp_t e;
        s_ch0 = s21(a);
        s_ch1 = s21(b);
        s_ch2 = s21(c);
        e.sel = 2'd0; e.data = s21(ref_cap(a)); e.last = 1'b0; sb.push_back(e);
        e.sel = 2'd1; e.data = s21(ref_cap(b)); e.last = 1'b0; sb.push_back(e);
        e.sel = 2'd2; e.data = s21(ref_cap(c)); e.last = 1'b1; sb.push_back(e);
    endtask

    // Pop and compare every downstream handshake.
    always @(negedge ap_clk) begin
        if (ap_rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                exp_t e;
                logic [W-1:0] d;
                e = sb.pop_front();
                d = (m_sel == 2'd0) ? m_d0 : (m_sel == 2'd1) ? m_d1 : m_d2;
                chk("xfer_sel",  32'(m_sel),  32'(e.sel));
                chk("xfer_data", 32'(d),      32'(e.data));
                chk("xfer_last", 32'(m_last), 32'(e.last));
            end
        end
    end

    initial begin
        ap_rst_n = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b0;
        s_ch0 = '0; s_ch1 = '0; s_ch2 = '0;
        repeat (3) step();

        // Reset state
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_sel",   32'(m_sel),   32'd0);
        chk("rst_last",  32'(m_last),  32'd0);
        chk("rst_d0",    32'(m_d0),    32'd0);
        chk("rst_ovr",   32'(ovr_cnt), 32'd0);
        ap_rst_n = 1'b1;
        step();
        chk("idle_ready_no_mready", 32'(s_ready), 32'd1);

        // Test 1: frame {5,-3,7} streamed with m_ready high
        drive_frame(5, -3, 7);
        s_valid = 1'b1;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("t1_latency_valid", 32'(m_valid), 32'd1);
        chk("t1_latency_sel",   32'(m_sel),   32'd0);
        chk("t1_busy_ready",    32'(s_ready), 32'd0);
        repeat (3) step();
        chk("t1_idle_valid", 32'(m_valid), 32'd0);
        chk("t1_idle_ready", 32'(s_ready), 32'd1);
        chk("t1_idle_sel",   32'(m_sel),   32'd2);
        chk("t1_idle_d1",    32'(m_d1),    32'(s21(-3)));
        chk("t1_sb_empty",   32'(sb.size()), 32'd0);

        // Test 2: stall 10 cycles in CH1
        drive_frame(11, -22, 33);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_sel",   32'(m_sel),   32'd1);
            chk("t2_hold_valid", 32'(m_valid), 32'd1);
            chk("t2_hold_d1",    32'(m_d1),    32'(s21(-22)));
            step();
        end
        m_ready = 1'b1;
        step();
        chk("t2_ch2_sel",  32'(m_sel),  32'd2);
        chk("t2_ch2_last", 32'(m_last), 32'd1);
        step();
        chk("t2_idle_valid", 32'(m_valid), 32'd0);

        // Test 3: s_valid held high, one frame every 4 cycles
        s_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("t3_ready_pattern", 32'(s_ready), 32'((k % 4) == 0));
            if ((k % 4) == 0) drive_frame(100 + k, -200 - k, 300 + k);
            step();
        end
        s_valid = 1'b0;
        chk("t3_ovr", 32'(ovr_cnt), 32'd9);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Test 4: overrun saturation while stalled in CH0
        m_ready = 1'b0;
        s_valid = 1'b1;
        drive_frame(1, 2, 3);
        step();
        for (int i = 0; i < 100; i++) step();
        chk("t4_ovr_mid", 32'(ovr_cnt), 32'd109);
        for (int i = 0; i < 200; i++) step();
        chk("t4_ovr_sat", 32'(ovr_cnt), 32'd255);
        step();
        chk("t4_ovr_hold", 32'(ovr_cnt), 32'd255);
        chk("t4_still_ch0", 32'(m_sel), 32'd0);

        // Test 5: asynchronous reset during CH1
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("t5_in_ch1", 32'(m_sel), 32'd1);
        #3 ap_rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(m_valid), 32'd0);
        chk("t5_async_sel",   32'(m_sel),   32'd0);
        chk("t5_async_d0",    32'(m_d0),    32'd0);
        chk("t5_async_ovr",   32'(ovr_cnt), 32'd0);
        chk("t5_async_ready", 32'(s_ready), 32'd1);
        sb.delete();
        step();
        step();
        #2 ap_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_post_valid", 32'(m_valid), 32'd0);
            chk("t5_post_ready", 32'(s_ready), 32'd1);
        end

        // Test 6: out-of-range frame, clamped only in the saturation build
        m_ready = 1'b1;
        s_valid = 1'b1;
        drive_frame(2000, -2000, 999);
        step();
        s_valid = 1'b0;
        chk("t6_d0", 32'(m_d0), 32'(s21(ref_cap(2000))));
        chk("t6_d1", 32'(m_d1), 32'(s21(ref_cap(-2000))));
        chk("t6_d2", 32'(m_d2), 32'(s21(ref_cap(999))));
        repeat (4) step();
        chk("t6_idle_hold_d0", 32'(m_d0), 32'(s21(ref_cap(2000))));
        chk("t6_idle_valid",   32'(m_valid), 32'd0);
        chk("t6_sb_empty",     32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
